// File: rtl/decoder_pkg.sv
// Shared decode/sequencing types: PC and writeback mux selects, sequencer states,
// and the width helper for the memory-ack timeout counter.
package decoder_pkg;

  typedef enum logic [0:0] {
    PC_NEXT   = 1'b0,
    PC_BRANCH = 1'b1
  } pc_mux_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_DM   = 2'd1,
    WB_CLIC = 2'd2
  } wb_data_mux_t;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    IRQ   = 3'd4,
    FAULT = 3'd5
  } seq_state_t;

  // Holds 0..TIMEOUT_CYCLES; a disabled timeout still gets a 1-bit counter.
  function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Memory and interrupt handshakes between the core sequencer and its bus/CLIC neighbours.
// master = sequencer side, slave = memory/CLIC side.
interface core_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dm_req;
  logic dm_we;
  logic dm_ack;
  logic clic_irq;
  logic clic_ack;

  modport master (
    output imem_req, dm_req, dm_we, clic_ack,
    input  imem_ack, dm_ack, clic_irq
  );

  modport slave (
    input  imem_req, dm_req, dm_we, clic_ack,
    output imem_ack, dm_ack, clic_irq
  );
endinterface

// File: rtl/bus_timeout.sv
// Wait-cycle counter shared by instruction fetch and data access; flags expiry when the
// final permitted cycle passes without an ack. TIMEOUT_CYCLES=0 disables it.
module bus_timeout
  import decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CW = timeout_cnt_w(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, reset_n, clear, active, ack};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (active && !ack && (cnt != SAT)) begin
          cnt <= cnt + CW'(1);
        end
      end

      // An ack on the last permitted cycle still completes the transfer.
      assign expired = active && !ack && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer with CLIC entry and fault trap.
// Define CORE_SEQUENCER_PERF_EN to add the instret/stall_cnt performance counters.
//
// state | meaning
// BOOT  | idle cycle after reset release
// FETCH | instruction fetch, waiting for imem_ack
// EXEC  | decode valid; retire ALU/branch ops or dispatch to MEM
// MEM   | data access, waiting for dm_ack
// IRQ   | interrupt entry: return address write and jump to vector
// FAULT | illegal instruction or bus timeout; left only by reset
module core_sequencer
  import decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  core_sequencer_if.master     bus,
  output logic                 ir_en,
  input  logic                 dec_load,
  input  logic                 dec_store,
  input  logic                 dec_wb_en,
  input  logic                 dec_illegal,
  input  logic                 branch_taken,
  output logic                 pc_en,
  output pc_mux_t              pc_mux,
  output logic                 rf_we,
  output wb_data_mux_t         wb_mux,
  output logic                 fault
`ifdef CORE_SEQUENCER_PERF_EN
  ,
  output logic [CNT_W-1:0]     instret,
  output logic [CNT_W-1:0]     stall_cnt
`endif
);

  seq_state_t state, state_nxt;
  logic       tmo_active, tmo_ack, tmo_clear, tmo_expired;

  assign tmo_active = (state == FETCH) || (state == MEM);
  assign tmo_ack    = (state == FETCH) ? bus.imem_ack : bus.dm_ack;
  assign tmo_clear  = !tmo_active || tmo_ack;

  bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bus_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .active  (tmo_active),
    .ack     (tmo_ack),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.imem_req = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.clic_ack = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_mux       = PC_NEXT;
    rf_we        = 1'b0;
    wb_mux       = WB_ALU;
    fault        = 1'b0;

    case (state)
      BOOT: state_nxt = FETCH;

      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_en     = 1'b1;
          state_nxt = EXEC;
        end else if (tmo_expired) begin
          state_nxt = FAULT;
        end
      end

      EXEC: begin
        if (dec_illegal) begin
          state_nxt = FAULT;
        end else if (dec_load || dec_store) begin
          state_nxt = MEM;
        end else begin
          rf_we     = dec_wb_en;
          pc_en     = 1'b1;
          pc_mux    = branch_taken ? PC_BRANCH : PC_NEXT;
          state_nxt = bus.clic_irq ? IRQ : FETCH;
        end
      end

      MEM: begin
        bus.dm_req = 1'b1;
        bus.dm_we  = dec_store;
        if (bus.dm_ack) begin
          rf_we     = dec_load;
          wb_mux    = WB_DM;
          pc_en     = 1'b1;
          state_nxt = bus.clic_irq ? IRQ : FETCH;
        end else if (tmo_expired) begin
          state_nxt = FAULT;
        end
      end

      IRQ: begin
        bus.clic_ack = 1'b1;
        rf_we        = 1'b1;
        wb_mux       = WB_CLIC;
        pc_en        = 1'b1;
        pc_mux       = PC_BRANCH;
        state_nxt    = FETCH;
      end

      FAULT: fault = 1'b1;

      default: state_nxt = FAULT;
    endcase
  end

`ifdef CORE_SEQUENCER_PERF_EN
  logic retire, stall;

  // IRQ also pulses pc_en but is not an instruction retirement.
  assign retire = pc_en && ((state == EXEC) || (state == MEM));
  assign stall  = (bus.imem_req && !bus.imem_ack) || (bus.dm_req && !bus.dm_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret   <= '0;
      stall_cnt <= '0;
    end else begin
      if (retire) instret   <= instret + CNT_W'(1);
      if (stall)  stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer (TIMEOUT_CYCLES=4): reset, ALU/branch/load/store
// flows, interrupt entry, fetch timeout, illegal trap, and perf counters when enabled.
module tb_core_sequencer;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic ir_en, pc_en, rf_we, fault;
  logic dec_load, dec_store, dec_wb_en, dec_illegal, branch_taken;
  pc_mux_t      pc_mux;
  wb_data_mux_t wb_mux;
`ifdef CORE_SEQUENCER_PERF_EN
  logic [31:0] instret, stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  core_sequencer_if bus_if ();

  core_sequencer #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus_if.master),
    .ir_en        (ir_en),
    .dec_load     (dec_load),
    .dec_store    (dec_store),
    .dec_wb_en    (dec_wb_en),
    .dec_illegal  (dec_illegal),
    .branch_taken (branch_taken),
    .pc_en        (pc_en),
    .pc_mux       (pc_mux),
    .rf_we        (rf_we),
    .wb_mux       (wb_mux),
    .fault        (fault)
`ifdef CORE_SEQUENCER_PERF_EN
    ,
    .instret      (instret),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {bus_if.imem_req, ir_en, bus_if.dm_req, bus_if.dm_we, bus_if.clic_ack,
                pc_en, pc_mux, rf_we, wb_mux, fault};

  function automatic logic [10:0] ov(input logic ireq, input logic iren, input logic dreq,
                                     input logic dwe, input logic cack, input logic pcen,
                                     input logic pcm, input logic rfw, input logic [1:0] wb,
                                     input logic flt);
    return {ireq, iren, dreq, dwe, cack, pcen, pcm, rfw, wb, flt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [10:0] V_IDLE   = 11'd0;
  localparam logic [10:0] V_FAULT  = 11'd1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] v_fetch_ack, v_fetch_wait, v_alu, v_mem_wait;
    v_fetch_ack  = ov(1, 1, 0, 0, 0, 0, 0, 0, WB_ALU, 0);
    v_fetch_wait = ov(1, 0, 0, 0, 0, 0, 0, 0, WB_ALU, 0);
    v_alu        = ov(0, 0, 0, 0, 0, 1, 0, 1, WB_ALU, 0);
    v_mem_wait   = ov(0, 0, 1, 0, 0, 0, 0, 0, WB_ALU, 0);

    reset_n = 1'b0;
    bus_if.imem_ack = 1'b0; bus_if.dm_ack = 1'b0; bus_if.clic_irq = 1'b0;
    dec_load = 1'b0; dec_store = 1'b0; dec_wb_en = 1'b0; dec_illegal = 1'b0;
    branch_taken = 1'b0;

    #2 chk("reset", obs, V_IDLE);
    bus_if.imem_ack = 1'b1; dec_wb_en = 1'b1;
    #1 chk("boot_ignores_ack", obs, V_IDLE);
    reset_n = 1'b1;

    // ALU ops with zero-wait fetch: one every 2 cycles
    step(); #1 chk("fetch0", obs, v_fetch_ack);
    step(); #1 chk("alu_exec0", obs, v_alu);
    step(); #1 chk("fetch1", obs, v_fetch_ack);
    step(); #1 chk("alu_exec1", obs, v_alu);

    step(); dec_wb_en = 1'b0; branch_taken = 1'b1;
    #1 chk("fetch_br", obs, v_fetch_ack);
    step(); #1 chk("branch_exec", obs, ov(0, 0, 0, 0, 0, 1, 1, 0, WB_ALU, 0));

    // Load with 3 wait cycles; ack lands on the last permitted timeout cycle
    step(); branch_taken = 1'b0; dec_wb_en = 1'b1; dec_load = 1'b1;
    #1 chk("fetch_ld", obs, v_fetch_ack);
    step(); bus_if.dm_ack = 1'b1;
    #1 chk("load_exec_ignores_ack", obs, V_IDLE);
    step(); bus_if.dm_ack = 1'b0;
    #1 chk("load_wait0", obs, v_mem_wait);
    step(); #1 chk("load_wait1", obs, v_mem_wait);
    step(); #1 chk("load_wait2", obs, v_mem_wait);
    step(); bus_if.dm_ack = 1'b1;
    #1 chk("load_ack", obs, ov(0, 0, 1, 0, 0, 1, 0, 1, WB_DM, 0));

    // Store with zero wait and an interrupt on the retiring cycle
    step(); bus_if.dm_ack = 1'b0; dec_load = 1'b0; dec_store = 1'b1;
    #1 chk("fetch_st", obs, v_fetch_ack);
    step(); #1 chk("store_exec", obs, V_IDLE);
    step(); bus_if.dm_ack = 1'b1; bus_if.clic_irq = 1'b1;
    #1 chk("store_ack_irq", obs, ov(0, 0, 1, 1, 0, 1, 0, 0, WB_DM, 0));
    step(); bus_if.dm_ack = 1'b0; bus_if.clic_irq = 1'b0; dec_store = 1'b0;
    #1 chk("irq_entry", obs, ov(0, 0, 0, 0, 1, 1, 1, 1, WB_CLIC, 0));

    // Interrupt pulse during fetch only: not taken
    step(); bus_if.imem_ack = 1'b0; bus_if.clic_irq = 1'b1;
    #1 chk("fetch_wait_irq", obs, v_fetch_wait);
    step(); bus_if.clic_irq = 1'b0; bus_if.imem_ack = 1'b1;
    #1 chk("fetch_late_ack", obs, v_fetch_ack);
    step(); #1 chk("alu_after_pulse", obs, v_alu);

    // Fetch timeout: 4 FETCH cycles without ack, then sticky fault
    step(); bus_if.imem_ack = 1'b0;
    #1 chk("no_irq_taken", obs, v_fetch_wait);
    for (int i = 1; i < 4; i++) begin
      step(); #1 chk($sformatf("tmo_fetch%0d", i), obs, v_fetch_wait);
    end
    step(); #1 chk("tmo_fault", obs, V_FAULT);
    step(); bus_if.imem_ack = 1'b1; bus_if.clic_irq = 1'b1;
    #1 chk("fault_sticky", obs, V_FAULT);

    #2 reset_n = 1'b0;
    #1 chk("async_reset_clears_fault", obs, V_IDLE);
    #1 reset_n = 1'b1; bus_if.clic_irq = 1'b0;

    // Illegal instruction traps from EXEC
    step(); dec_illegal = 1'b1;
    #1 chk("fetch_ill", obs, v_fetch_ack);
    step(); #1 chk("illegal_exec", obs, V_IDLE);
    step(); #1 chk("illegal_fault", obs, V_FAULT);

    // Reset while a load is in flight: request drops, no write
    #2 reset_n = 1'b0;
    #1 reset_n = 1'b1; dec_illegal = 1'b0; dec_load = 1'b1;
    step(); step(); step();
    #1 chk("mem_inflight", obs, v_mem_wait);
    #2 reset_n = 1'b0;
    #1 chk("reset_mid_mem", obs, V_IDLE);
    #1 reset_n = 1'b1; dec_load = 1'b0;

`ifdef CORE_SEQUENCER_PERF_EN
    chk("instret_reset", instret, 32'd0);
    chk("stall_reset", stall_cnt, 32'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      step(); step();
    end
    #1 chk("instret_10", instret, 32'd10);
    chk("stall_0", stall_cnt, 32'd0);
    dec_load = 1'b1;
    step();
    step(); step();
    step(); bus_if.dm_ack = 1'b1;
    step(); bus_if.dm_ack = 1'b0; dec_load = 1'b0;
    #1 chk("instret_11", instret, 32'd11);
    chk("stall_2", stall_cnt, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
